// File: rtl/norm_shift_left.sv
// Sequential left-normalizer: binary-search shifts (16,8,4,2,1), one stage per clock,
// producing normalized mantissa, adjusted exponent, leading-zero count and flags.
module norm_shift_left #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int LZC_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [LZC_W-1:0]  lzc,
    output logic              zero,
    output logic              underflow
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [2:0] LAST_STAGE = 3'd4;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_stage;
    logic [MANT_W-1:0]   r_mant, w_mant_nxt;
    logic [LZC_W-1:0]    r_lzc, w_lzc_nxt;
    logic [EXP_W-1:0]    r_exp;
    logic                r_zero;

    logic [MANT_W-1:0]   r_mant_out;
    logic [EXP_W-1:0]    r_exp_out;
    logic [LZC_W-1:0]    r_lzc_out;
    logic                r_zero_out;
    logic                r_uf_out;

    logic [4:0]          w_width;
    logic [5:0]          w_top_lsb;
    logic                w_top_zero;
    logic                w_uf;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign mant_out  = r_mant_out;
    assign exp_out   = r_exp_out;
    assign lzc       = r_lzc_out;
    assign zero      = r_zero_out;
    assign underflow = r_uf_out;

    // Stage width halves each clock; the test looks at the top w bits of the working mantissa.
    always_comb begin
        w_width    = 5'd16 >> r_stage;
        w_top_lsb  = 6'(MANT_W) - 6'(w_width);
        w_top_zero = ((r_mant >> w_top_lsb) == '0);
        w_mant_nxt = w_top_zero ? (r_mant << w_width) : r_mant;
        w_lzc_nxt  = w_top_zero ? (r_lzc + LZC_W'(w_width)) : r_lzc;
        w_uf       = (32'(r_exp) <= 32'(w_lzc_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)                 w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_stage == LAST_STAGE)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)                w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_mant     <= '0;
            r_lzc      <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
            r_mant_out <= '0;
            r_exp_out  <= '0;
            r_lzc_out  <= '0;
            r_zero_out <= 1'b0;
            r_uf_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mant  <= mant_in;
                        r_exp   <= exp_in;
                        r_lzc   <= '0;
                        r_zero  <= (mant_in == '0);
                        r_stage <= '0;
                    end
                end
                S_SHIFT: begin
                    r_mant  <= w_mant_nxt;
                    r_lzc   <= w_lzc_nxt;
                    r_stage <= r_stage + 3'd1;
                    // Results are taken from the stage-4 combinational values on the DONE-entry edge.
                    if (r_stage == LAST_STAGE) begin
                        r_stage <= '0;
                        if (r_zero) begin
                            r_mant_out <= '0;
                            r_exp_out  <= '0;
                            r_lzc_out  <= LZC_W'(MANT_W);
                            r_zero_out <= 1'b1;
                            r_uf_out   <= 1'b0;
                        end else begin
                            r_mant_out <= w_mant_nxt;
                            r_lzc_out  <= w_lzc_nxt;
                            r_zero_out <= 1'b0;
                            r_uf_out   <= w_uf;
                            r_exp_out  <= w_uf ? '0 : (r_exp - EXP_W'(w_lzc_nxt));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
